// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (core LSU = 0, DMA = 1) arbiter for a single
// synchronous data-memory port with round-robin priority, out-of-range
// detection and one-cycle read return.
// Optional burst locking is compiled in when MEM_ARB_LOCK_EN is defined;
// without it, i_lock_0/i_lock_1 are ignored and arbitration is pure round-robin.
module mem_arbiter #(
  parameter int MAX_LOCK = 16,
  parameter int MEM_AW   = 9
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_req_0,
  input  logic [31:0]       i_addr_0,
  input  logic [31:0]       i_wdata_0,
  input  logic [3:0]        i_bmask_0,
  input  logic              i_wren_0,
  input  logic              i_lock_0,
  input  logic              i_req_1,
  input  logic [31:0]       i_addr_1,
  input  logic [31:0]       i_wdata_1,
  input  logic [3:0]        i_bmask_1,
  input  logic              i_wren_1,
  input  logic              i_lock_1,
  output logic              o_gnt_0,
  output logic              o_rvalid_0,
  output logic [31:0]       o_rdata_0,
  output logic              o_err_0,
  output logic              o_gnt_1,
  output logic              o_rvalid_1,
  output logic [31:0]       o_rdata_1,
  output logic              o_err_1,
  output logic [MEM_AW-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_bmask,
  output logic              o_mem_wren,
  input  logic [31:0]       i_mem_rdata
);

  // Priority pointer: 0 favours the core, 1 favours the DMA on a tie.
  logic prio_q, prio_d;

  // Per-requester read return tracking: rvalid_q marks a read granted last
  // cycle, rzero_q marks that it was out of range and must return zero.
  logic [1:0] rvalid_q, rvalid_d;
  logic [1:0] rzero_q, rzero_d;

  logic in_range_0, in_range_1;
  logic mem_en;

  // An address is in range when every bit above the word-address field is 0.
  assign in_range_0 = (i_addr_0[31:MEM_AW+2] == '0);
  assign in_range_1 = (i_addr_1[31:MEM_AW+2] == '0);

`ifdef MEM_ARB_LOCK_EN
  localparam int CW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Word-offset bits are never needed by a word-wide memory.
  logic unused_ok;
  assign unused_ok = ^{i_addr_0[1:0], i_addr_1[1:0]};

  // Grant selection and next-state for arbitration with burst locking.
  always_comb begin
    o_gnt_0 = 1'b0;
    o_gnt_1 = 1'b0;
    prio_d  = prio_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_LOCK0: begin
        if (i_req_0) begin
          o_gnt_0 = 1'b1;
          if (!i_lock_0 || cnt_q == CW'(MAX_LOCK - 1)) begin
            state_d = ST_ARB;
            prio_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          state_d = ST_ARB;
          cnt_d   = '0;
        end
      end
      ST_LOCK1: begin
        if (i_req_1) begin
          o_gnt_1 = 1'b1;
          if (!i_lock_1 || cnt_q == CW'(MAX_LOCK - 1)) begin
            state_d = ST_ARB;
            prio_d  = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          state_d = ST_ARB;
          cnt_d   = '0;
        end
      end
      default: begin
        if (i_req_0 && (!i_req_1 || !prio_q)) begin
          o_gnt_0 = 1'b1;
          prio_d  = 1'b1;
          if (i_lock_0) begin
            state_d = ST_LOCK0;
            cnt_d   = CW'(1);
          end
        end else if (i_req_1) begin
          o_gnt_1 = 1'b1;
          prio_d  = 1'b0;
          if (i_lock_1) begin
            state_d = ST_LOCK1;
            cnt_d   = CW'(1);
          end
        end
      end
    endcase
  end

  // Lock state and lock counter registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_ARB;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  // Lock inputs have no effect in this build; word-offset bits are never needed.
  logic unused_ok;
  assign unused_ok = ^{i_addr_0[1:0], i_addr_1[1:0], i_lock_0, i_lock_1};

  // Pure round-robin grant selection.
  always_comb begin
    o_gnt_0 = 1'b0;
    o_gnt_1 = 1'b0;
    prio_d  = prio_q;
    if (i_req_0 && (!i_req_1 || !prio_q)) begin
      o_gnt_0 = 1'b1;
      prio_d  = 1'b1;
    end else if (i_req_1) begin
      o_gnt_1 = 1'b1;
      prio_d  = 1'b0;
    end
  end
`endif

  assign o_err_0 = o_gnt_0 & ~in_range_0;
  assign o_err_1 = o_gnt_1 & ~in_range_1;
  assign mem_en  = (o_gnt_0 & in_range_0) | (o_gnt_1 & in_range_1);

  // Memory port mux: granted requester's fields, all-zero when idle or out of range.
  always_comb begin
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_bmask = 4'b0000;
    o_mem_wren  = 1'b0;
    if (mem_en) begin
      if (o_gnt_1) begin
        o_mem_addr  = i_addr_1[MEM_AW+1:2];
        o_mem_wdata = i_wdata_1;
        o_mem_bmask = i_bmask_1;
        o_mem_wren  = i_wren_1;
      end else begin
        o_mem_addr  = i_addr_0[MEM_AW+1:2];
        o_mem_wdata = i_wdata_0;
        o_mem_bmask = i_bmask_0;
        o_mem_wren  = i_wren_0;
      end
    end
  end

  // A granted read returns next cycle; out-of-range reads return zero.
  always_comb begin
    rvalid_d = {o_gnt_1 & ~i_wren_1, o_gnt_0 & ~i_wren_0};
    rzero_d  = {~in_range_1, ~in_range_0};
  end

  // Priority pointer and read-return registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      prio_q   <= 1'b0;
      rvalid_q <= 2'b00;
      rzero_q  <= 2'b00;
    end else begin
      prio_q   <= prio_d;
      rvalid_q <= rvalid_d;
      rzero_q  <= rzero_d;
    end
  end

  assign o_rvalid_0 = rvalid_q[0];
  assign o_rvalid_1 = rvalid_q[1];
  assign o_rdata_0  = (rvalid_q[0] && !rzero_q[0]) ? i_mem_rdata : 32'h0;
  assign o_rdata_1  = (rvalid_q[1] && !rzero_q[1]) ? i_mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus hand-written sequences for
// lock bursts and reset with a read in flight (lock part when
// MEM_ARB_LOCK_EN is defined, lock-ignored check otherwise).
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req_0, req_1, wren_0, wren_1, lock_0, lock_1;
  logic [31:0] addr_0, addr_1, wdata_0, wdata_1, mem_rdata;
  logic [3:0]  bmask_0, bmask_1;
  logic        gnt_0, gnt_1, rvalid_0, rvalid_1, err_0, err_1, mem_wren;
  logic [31:0] rdata_0, rdata_1, mem_wdata;
  logic [3:0]  mem_bmask;
  logic [8:0]  mem_addr;

  int n_checks = 0;
  int n_miss   = 0;

  mem_arbiter #(.MAX_LOCK(16), .MEM_AW(9)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_req_0(req_0), .i_addr_0(addr_0), .i_wdata_0(wdata_0),
    .i_bmask_0(bmask_0), .i_wren_0(wren_0), .i_lock_0(lock_0),
    .i_req_1(req_1), .i_addr_1(addr_1), .i_wdata_1(wdata_1),
    .i_bmask_1(bmask_1), .i_wren_1(wren_1), .i_lock_1(lock_1),
    .o_gnt_0(gnt_0), .o_rvalid_0(rvalid_0), .o_rdata_0(rdata_0), .o_err_0(err_0),
    .o_gnt_1(gnt_1), .o_rvalid_1(rvalid_1), .o_rdata_1(rdata_1), .o_err_1(err_1),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_bmask(mem_bmask),
    .o_mem_wren(mem_wren), .i_mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        r0, r1, w0, w1;
    logic [31:0] a0, a1, wd0, wd1;
    logic [3:0]  bm0, bm1;
    logic [31:0] mrd;
    logic        g0, g1, e0, e1;
    logic [8:0]  maddr;
    logic [31:0] mwd;
    logic [3:0]  mbm;
    logic        mwr, rv0, rv1;
    logic [31:0] rd0, rd1;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req_0 = 0; req_1 = 0; wren_0 = 0; wren_1 = 0; lock_0 = 0; lock_1 = 0;
    addr_0 = 0; addr_1 = 0; wdata_0 = 0; wdata_1 = 0; bmask_0 = 0; bmask_1 = 0;
  endtask

  initial begin
    // r0 r1 w0 w1 a0 a1 wd0 wd1 bm0 bm1 mrd | g0 g1 e0 e1 maddr mwd mbm mwr rv0 rv1 rd0 rd1
    vecs[0]  = '{0,0,0,0, 32'h0,32'h0, 32'h0,32'h0, 4'h0,4'h0, 32'h5555_5555,
                 0,0,0,0, 9'h000, 32'h0, 4'h0, 0, 0,0, 32'h0,32'h0};
    vecs[1]  = '{1,1,0,0, 32'h10,32'h20, 32'h1111_1111,32'h2222_2222, 4'h0,4'h0, 32'h0,
                 1,0,0,0, 9'h004, 32'h1111_1111, 4'h0, 0, 0,0, 32'h0,32'h0};
    vecs[2]  = '{0,1,0,0, 32'h0,32'h20, 32'h0,32'h2222_2222, 4'h0,4'h0, 32'hAAAA_0001,
                 0,1,0,0, 9'h008, 32'h2222_2222, 4'h0, 0, 1,0, 32'hAAAA_0001,32'h0};
    vecs[3]  = '{0,0,0,0, 32'h0,32'h0, 32'h0,32'h0, 4'h0,4'h0, 32'hBBBB_0002,
                 0,0,0,0, 9'h000, 32'h0, 4'h0, 0, 0,1, 32'h0,32'hBBBB_0002};
    vecs[4]  = '{1,1,0,0, 32'h100,32'h104, 32'h0,32'h0, 4'h0,4'h0, 32'h0,
                 1,0,0,0, 9'h040, 32'h0, 4'h0, 0, 0,0, 32'h0,32'h0};
    vecs[5]  = '{1,1,0,0, 32'h100,32'h104, 32'h0,32'h0, 4'h0,4'h0, 32'hC0C0_0005,
                 0,1,0,0, 9'h041, 32'h0, 4'h0, 0, 1,0, 32'hC0C0_0005,32'h0};
    vecs[6]  = '{1,1,0,0, 32'h100,32'h104, 32'h0,32'h0, 4'h0,4'h0, 32'hC1C1_0006,
                 1,0,0,0, 9'h040, 32'h0, 4'h0, 0, 0,1, 32'h0,32'hC1C1_0006};
    vecs[7]  = '{1,1,0,0, 32'h100,32'h104, 32'h0,32'h0, 4'h0,4'h0, 32'hC2C2_0007,
                 0,1,0,0, 9'h041, 32'h0, 4'h0, 0, 1,0, 32'hC2C2_0007,32'h0};
    vecs[8]  = '{0,0,0,0, 32'h0,32'h0, 32'h0,32'h0, 4'h0,4'h0, 32'hC3C3_0008,
                 0,0,0,0, 9'h000, 32'h0, 4'h0, 0, 0,1, 32'h0,32'hC3C3_0008};
    vecs[9]  = '{1,0,1,0, 32'h1000_0000,32'h0, 32'hDEAD_BEEF,32'h0, 4'hF,4'h0, 32'h0,
                 1,0,1,0, 9'h000, 32'h0, 4'h0, 0, 0,0, 32'h0,32'h0};
    vecs[10] = '{0,1,0,0, 32'h0,32'h800, 32'h0,32'h3333_3333, 4'h0,4'hF, 32'h9999_9999,
                 0,1,0,1, 9'h000, 32'h0, 4'h0, 0, 0,0, 32'h0,32'h0};
    vecs[11] = '{0,0,0,0, 32'h0,32'h0, 32'h0,32'h0, 4'h0,4'h0, 32'h1234_5678,
                 0,0,0,0, 9'h000, 32'h0, 4'h0, 0, 0,1, 32'h0,32'h0};
    vecs[12] = '{0,1,0,1, 32'h0,32'h7FC, 32'h0,32'h00AB_0000, 4'h0,4'h4, 32'h0,
                 0,1,0,0, 9'h1FF, 32'h00AB_0000, 4'h4, 1, 0,0, 32'h0,32'h0};
    vecs[13] = '{0,0,0,0, 32'h0,32'h0, 32'h0,32'h0, 4'h0,4'h0, 32'h7777_7777,
                 0,0,0,0, 9'h000, 32'h0, 4'h0, 0, 0,0, 32'h0,32'h0};
    vecs[14] = '{0,1,0,0, 32'h0,32'h0, 32'h0,32'h4444_4444, 4'h0,4'hF, 32'h0,
                 0,1,0,0, 9'h000, 32'h4444_4444, 4'hF, 0, 0,0, 32'h0,32'h0};
    vecs[15] = '{0,0,0,0, 32'h0,32'h0, 32'h0,32'h0, 4'h0,4'h0, 32'hCAFE_F00D,
                 0,0,0,0, 9'h000, 32'h0, 4'h0, 0, 0,1, 32'h0,32'hCAFE_F00D};
    vecs[16] = '{1,0,1,0, 32'h4,32'h0, 32'h0102_0304,32'h0, 4'h3,4'h0, 32'h0,
                 1,0,0,0, 9'h001, 32'h0102_0304, 4'h3, 1, 0,0, 32'h0,32'h0};
    vecs[17] = '{1,1,0,0, 32'h8,32'hC, 32'h0,32'h0, 4'hF,4'hF, 32'h0,
                 0,1,0,0, 9'h003, 32'h0, 4'hF, 0, 0,0, 32'h0,32'h0};
    vecs[18] = '{1,1,0,0, 32'h8,32'hC, 32'h0,32'h0, 4'hF,4'hF, 32'h0BAD_0001,
                 1,0,0,0, 9'h002, 32'h0, 4'hF, 0, 0,1, 32'h0,32'h0BAD_0001};

    idle_inputs();
    mem_rdata = 32'h0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_rvalid0", 32'(rvalid_0), 32'h0);
    chk("reset_rvalid1", 32'(rvalid_1), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: drive on the falling edge, compare 2 time units later.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      req_0 = vecs[i].r0;   req_1 = vecs[i].r1;
      wren_0 = vecs[i].w0;  wren_1 = vecs[i].w1;
      addr_0 = vecs[i].a0;  addr_1 = vecs[i].a1;
      wdata_0 = vecs[i].wd0; wdata_1 = vecs[i].wd1;
      bmask_0 = vecs[i].bm0; bmask_1 = vecs[i].bm1;
      mem_rdata = vecs[i].mrd;
      #2;
      chk($sformatf("v%0d_gnt0", i), 32'(gnt_0), 32'(vecs[i].g0));
      chk($sformatf("v%0d_gnt1", i), 32'(gnt_1), 32'(vecs[i].g1));
      chk($sformatf("v%0d_err0", i), 32'(err_0), 32'(vecs[i].e0));
      chk($sformatf("v%0d_err1", i), 32'(err_1), 32'(vecs[i].e1));
      chk($sformatf("v%0d_maddr", i), 32'(mem_addr), 32'(vecs[i].maddr));
      chk($sformatf("v%0d_mwdata", i), mem_wdata, vecs[i].mwd);
      chk($sformatf("v%0d_mbmask", i), 32'(mem_bmask), 32'(vecs[i].mbm));
      chk($sformatf("v%0d_mwren", i), 32'(mem_wren), 32'(vecs[i].mwr));
      chk($sformatf("v%0d_rvalid0", i), 32'(rvalid_0), 32'(vecs[i].rv0));
      chk($sformatf("v%0d_rvalid1", i), 32'(rvalid_1), 32'(vecs[i].rv1));
      chk($sformatf("v%0d_rdata0", i), rdata_0, vecs[i].rd0);
      chk($sformatf("v%0d_rdata1", i), rdata_1, vecs[i].rd1);
      $display("vec %0d: gnt=%b%b err=%b%b maddr=%h wren=%b bmask=%h rvalid=%b%b",
               i, gnt_1, gnt_0, err_1, err_0, mem_addr, mem_wren, mem_bmask, rvalid_1, rvalid_0);
    end

    // Lock burst: DMA holds lock with both requesting.
    @(negedge clk);
    idle_inputs();
    req_1 = 1; wren_1 = 1; lock_1 = 1; addr_1 = 32'h40; bmask_1 = 4'hF;
    #2;
    chk("lock_first_gnt1", 32'(gnt_1), 32'h1);
    $display("lock cycle 0: gnt=%b%b", gnt_1, gnt_0);
`ifdef MEM_ARB_LOCK_EN
    req_0 = 1; wren_0 = 1; addr_0 = 32'h44; bmask_0 = 4'hF;
    for (int c = 1; c < 16; c++) begin
      @(negedge clk);
      #2;
      chk($sformatf("lock_c%0d_gnt1", c), 32'(gnt_1), 32'h1);
      chk($sformatf("lock_c%0d_gnt0", c), 32'(gnt_0), 32'h0);
      $display("lock cycle %0d: gnt=%b%b", c, gnt_1, gnt_0);
    end
    @(negedge clk);
    #2;
    chk("lock_release_gnt0", 32'(gnt_0), 32'h1);
    chk("lock_release_gnt1", 32'(gnt_1), 32'h0);
    $display("lock cycle 16: gnt=%b%b", gnt_1, gnt_0);
`else
    @(negedge clk);
    req_0 = 1; wren_0 = 1; addr_0 = 32'h44; bmask_0 = 4'hF;
    #2;
    chk("nolock_gnt0", 32'(gnt_0), 32'h1);
    chk("nolock_gnt1", 32'(gnt_1), 32'h0);
    $display("lock ignored cycle 1: gnt=%b%b", gnt_1, gnt_0);
`endif

    // Reset with a DMA read in flight (and a held lock when enabled).
    @(negedge clk);
    idle_inputs();
    req_1 = 1; lock_1 = 1; addr_1 = 32'h20;
    mem_rdata = 32'hFEED_FACE;
    #2;
    chk("rst_seq_gnt1", 32'(gnt_1), 32'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("rst_async_rvalid1", 32'(rvalid_1), 32'h0);
    chk("rst_async_rdata1", rdata_1, 32'h0);
    $display("reset asserted mid-read: rvalid1=%b rdata1=%h", rvalid_1, rdata_1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rst_hold%0d_rvalid1", c), 32'(rvalid_1), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req_0 = 1; req_1 = 1; lock_1 = 1; addr_0 = 32'h30; addr_1 = 32'h34;
    #2;
    chk("post_rst_gnt0", 32'(gnt_0), 32'h1);
    chk("post_rst_gnt1", 32'(gnt_1), 32'h0);
    chk("post_rst_rvalid1", 32'(rvalid_1), 32'h0);
    $display("after reset: gnt=%b%b", gnt_1, gnt_0);
    @(negedge clk);
    idle_inputs();
    mem_rdata = 32'h0123_4567;
    #2;
    chk("post_rst_rvalid0", 32'(rvalid_0), 32'h1);
    chk("post_rst_rdata0", rdata_0, 32'h0123_4567);
    chk("post_rst_rvalid1_b", 32'(rvalid_1), 32'h0);
    $display("after reset +1: rvalid=%b%b rdata0=%h", rvalid_1, rvalid_0, rdata_0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_LOCK, default 16: max consecutive granted cycles one requester may hold a lock.
REQ-002 Parameter MEM_AW, default 9: data-memory word-address width (2 KiB, 0x0000_0000-0x0000_07FF).
REQ-003 i_clk  in  1  sole clock, all state on rising edge.
REQ-004 i_reset_n  in  1  asynchronous, active-low reset.
REQ-005 i_req_k (k=0 core LSU, k=1 DMA)  in  1  access request, per requester.
REQ-006 i_addr_k  in  32  byte address, per requester.
REQ-007 i_wdata_k  in  32; i_bmask_k  in  4; i_wren_k  in  1: store data, byte mask, write enable, per requester.
REQ-008 i_lock_k  in  1  hold grant for burst, per requester.
REQ-009 o_gnt_k  out  1  access accepted this cycle, per requester.
REQ-010 o_rvalid_k  out  1; o_rdata_k  out  32: load return, per requester.
REQ-011 o_err_k  out  1  out-of-range access flag, per requester.
REQ-012 o_mem_addr  out  MEM_AW; o_mem_wdata  out  32; o_mem_bmask  out  4; o_mem_wren  out  1: memory port.
REQ-013 i_mem_rdata  in  32  memory read data, valid one cycle after address presented.

Function
REQ-014 Requester SHALL hold i_req_k, address, data, mask, wren, lock stable until o_gnt_k seen high; o_gnt_k combinational, at most one o_gnt high per cycle.
REQ-015 State machine: ARB, LOCK0, LOCK1; plus 1-bit priority pointer prio.
REQ-016 ARB: only one requester -> grant it; both -> grant prio; after any grant to k, prio <= other requester.
REQ-017 ARB, grant to k with i_lock_k=1 -> next state LOCKk, lock counter <= 1.
REQ-018 LOCKk: only k grantable, other requester stalled (o_gnt low) regardless of prio.
REQ-019 LOCKk, i_req_k=1 and i_lock_k=0 -> grant k, next state ARB, prio <= other.
REQ-020 LOCKk, i_req_k=0 -> no grant this cycle, next state ARB.
REQ-021 LOCKk, granted with counter == MAX_LOCK-1 -> next state ARB, prio <= other (forced release), counter <= 0; else counter increments on each grant.
REQ-022 Granted address in 0x0000_0000-0x0000_07FF: o_mem_addr = addr[MEM_AW+1:2], o_mem_wdata/o_mem_bmask/o_mem_wren = granted requester's values.
REQ-023 No grant or granted address out of range: o_mem_wren=0, o_mem_bmask=4'b0000, o_mem_addr/o_mem_wdata=0.
REQ-024 Out-of-range grant SHALL still assert o_gnt_k and pulse o_err_k same cycle; if a read, o_rvalid_k next cycle with o_rdata_k=0.
REQ-025 In-range read granted cycle N -> o_rvalid_k=1 and o_rdata_k=i_mem_rdata at cycle N+1 only; o_rdata_k=0 when o_rvalid_k=0.
REQ-026 Writes produce no o_rvalid; back-to-back grants SHALL be sustained at one access per cycle with no bubble.

Reset
REQ-027 Asserting i_reset_n low SHALL immediately force: state ARB, prio=0, lock counter 0, o_rvalid_k=0, o_rdata_k=0; combinational outputs follow from this state.
REQ-028 Reset mid-lock or with a read in flight SHALL drop the lock and discard the pending o_rvalid.

Configuration
REQ-029 Macro MEM_ARB_LOCK_EN defined: lock behaviour per REQ-017 to REQ-021 compiled in.
REQ-030 MEM_ARB_LOCK_EN undefined: i_lock_k ignored, lock states and counter absent, pure round-robin per REQ-016.

Verification
REQ-031 Both request reads 0x10 and 0x20 after reset -> core granted cycle 0, DMA cycle 1, each o_rvalid one cycle after its grant with memory data.
REQ-032 Both request continuously, no lock -> grants alternate 0,1,0,1; no cycle without a grant.
REQ-033 MEM_ARB_LOCK_EN, DMA lock=1 with continuous requests, core requesting, MAX_LOCK=16 -> DMA granted 16 consecutive cycles, then core granted.
REQ-034 Core store 0x1000_0000 -> o_gnt_0=1, o_err_0=1, o_mem_wren=0, o_mem_bmask=0.
REQ-035 Store byte mask 4'b0100 to 0x7FC -> o_mem_addr=0x1FF, o_mem_bmask=4'b0100, o_mem_wren=1, no o_rvalid.
REQ-036 i_reset_n low during LOCK1 with read in flight -> o_rvalid_1 never rises; after release core with req=1 is granted first cycle.
